// File: rtl/bram_master_pkg.sv
// Shared types and constants for the block-RAM burst master and its read FIFO.
package bram_master_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  localparam int FIFO_DEPTH = 2;
  localparam int FIFO_CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int FIFO_IDX_W = $clog2(FIFO_DEPTH);

endpackage

// File: rtl/bram_burst_master_rd_skid_fifo.sv
// Two-entry FIFO that catches registered RAM read data ahead of the read stream.
module rd_skid_fifo
  import bram_master_pkg::*;
#(
  parameter int DATA = 8
) (
  input  logic                  clk,
  input  logic                  nRESET,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA-1:0]       din,
  output logic [DATA-1:0]       head,
  output logic                  full,
  output logic                  empty,
  output logic [FIFO_CNT_W-1:0] count
);

  logic [DATA-1:0]       mem [FIFO_DEPTH];
  logic [FIFO_IDX_W-1:0] wr_idx;
  logic [FIFO_IDX_W-1:0] rd_idx;
  logic                  do_push;
  logic                  do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FIFO_CNT_W'(FIFO_DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_idx];

  always_ff @(posedge clk or negedge nRESET) begin
    if (!nRESET) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_idx <= '0;
      rd_idx <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_idx] <= din;
        wr_idx      <= wr_idx + FIFO_IDX_W'(1);
      end
      if (do_pop) rd_idx <= rd_idx + FIFO_IDX_W'(1);
      if (do_push && !do_pop)      count <= count + FIFO_CNT_W'(1);
      else if (do_pop && !do_push) count <= count - FIFO_CNT_W'(1);
    end
  end

endmodule

// File: rtl/bram_burst_master.sv
// Turns one {addr, len, dir} command into a burst on a block-RAM port,
// with data carried over valid/ready streams.
//
// state | meaning
// IDLE  | waiting for a command, cmd_ready high
// WRITE | one RAM write per accepted write-data word
// READ  | issuing reads while the FIFO has room
// DRAIN | all reads issued, emptying FIFO to the consumer
module bram_burst_master
  import bram_master_pkg::*;
#(
  parameter int DATA = 8,
  parameter int ADDR = 15
) (
  input  logic            clk,
  input  logic            nRESET,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic            cmd_wr,
  input  logic [ADDR-1:0] cmd_addr,
  input  logic [ADDR-1:0] cmd_len,
  input  logic            wd_valid,
  output logic            wd_ready,
  input  logic [DATA-1:0] wd_data,
  output logic            rd_valid,
  input  logic            rd_ready,
  output logic [DATA-1:0] rd_data,
  output logic            busy,
  output logic            done,
  output logic            m_en,
  output logic            m_wr,
  output logic [ADDR-1:0] m_addr,
  output logic [DATA-1:0] m_din,
  input  logic [DATA-1:0] m_dout
);

  state_t                state, state_nx;
  logic [ADDR-1:0]       ptr, remaining;
  logic                  inflight, done_q, finish;
  logic                  accept, last_word, rd_pop, room, issue_wr, issue_rd;
  logic [DATA-1:0]       fifo_head;
  logic                  fifo_full, fifo_empty;
  logic [FIFO_CNT_W-1:0] fifo_count;

  assign accept    = cmd_valid & cmd_ready;
  assign last_word = (remaining == '0);
  assign rd_pop    = rd_valid & rd_ready;
  // A word popped this cycle frees its slot, so a steady consumer sees one word per cycle.
  assign room      = rd_pop | (~fifo_full & ~(inflight & ~fifo_empty));
  assign issue_wr  = (state == WRITE) & wd_valid;
  assign issue_rd  = (state == READ) & room;

  always_comb begin
    state_nx = state;
    finish   = 1'b0;
    case (state)
      IDLE:  if (accept) state_nx = cmd_wr ? WRITE : READ;
      WRITE: if (issue_wr && last_word) begin
               state_nx = IDLE;
               finish   = 1'b1;
             end
      READ:  if (issue_rd && last_word) state_nx = DRAIN;
      DRAIN: if (!inflight && fifo_count == FIFO_CNT_W'(1) && rd_pop) begin
               state_nx = IDLE;
               finish   = 1'b1;
             end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nRESET) begin
    if (!nRESET) state <= IDLE;
    else         state <= state_nx;
  end

  always_ff @(posedge clk or negedge nRESET) begin
    if (!nRESET) begin
      ptr       <= '0;
      remaining <= '0;
      inflight  <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      if (accept) begin
        ptr       <= cmd_addr;
        remaining <= cmd_len;
      end else if (issue_wr || issue_rd) begin
        ptr       <= ptr + ADDR'(1);
        remaining <= remaining - ADDR'(1);
      end
      inflight <= issue_rd;
      done_q   <= finish;
    end
  end

  rd_skid_fifo #(.DATA(DATA)) u_fifo (
    .clk    (clk),
    .nRESET (nRESET),
    .push   (inflight),
    .pop    (rd_pop),
    .din    (m_dout),
    .head   (fifo_head),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .count  (fifo_count)
  );

  assign cmd_ready = (state == IDLE);
  assign busy      = ~cmd_ready;
  assign wd_ready  = (state == WRITE);
  assign m_en      = issue_wr | issue_rd;
  assign m_wr      = issue_wr;
  assign m_addr    = ptr;
  assign m_din     = issue_wr ? wd_data : '0;
  assign rd_valid  = ~fifo_empty;
  assign rd_data   = fifo_head;
  assign done      = done_q;

endmodule

// File: tb/tb_bram_burst_master.sv
// Bench for bram_burst_master: behavioural RAM on the memory port, a flat
// reference memory for expected data, table-driven bursts plus corner sequences.
module tb_bram_burst_master;

  localparam int DATA      = 8;
  localparam int ADDR      = 15;
  localparam int MEM_WORDS = 1 << ADDR;

  logic            clk = 1'b0;
  logic            nRESET;
  logic            cmd_valid, cmd_ready, cmd_wr;
  logic [ADDR-1:0] cmd_addr, cmd_len;
  logic            wd_valid, wd_ready;
  logic [DATA-1:0] wd_data;
  logic            rd_valid, rd_ready;
  logic [DATA-1:0] rd_data;
  logic            busy, done, m_en, m_wr;
  logic [ADDR-1:0] m_addr;
  logic [DATA-1:0] m_din, m_dout;

  logic [DATA-1:0] ram     [MEM_WORDS];
  logic [DATA-1:0] ref_mem [MEM_WORDS];

  int n_pass = 0;
  int n_total = 0;

  typedef struct {
    bit              wr;
    logic [ADDR-1:0] addr;
    int              len;
    int              mode;      // 0: always valid/ready, 1: one cycle in three, 2: random
    logic [DATA-1:0] dbase;
    logic [DATA-1:0] dstep;
    logic [ADDR-1:0] exp_last;  // address of the final RAM access
  } vec_t;

  localparam int NV = 6;
  vec_t vecs [NV];

  bram_burst_master #(.DATA(DATA), .ADDR(ADDR)) dut (
    .clk       (clk),
    .nRESET    (nRESET),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_wr    (cmd_wr),
    .cmd_addr  (cmd_addr),
    .cmd_len   (cmd_len),
    .wd_valid  (wd_valid),
    .wd_ready  (wd_ready),
    .wd_data   (wd_data),
    .rd_valid  (rd_valid),
    .rd_ready  (rd_ready),
    .rd_data   (rd_data),
    .busy      (busy),
    .done      (done),
    .m_en      (m_en),
    .m_wr      (m_wr),
    .m_addr    (m_addr),
    .m_din     (m_din),
    .m_dout    (m_dout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (m_en) begin
      if (m_wr) ram[m_addr] <= m_din;
      else      m_dout      <= ram[m_addr];
    end
  end

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset(string tag);
    chk({tag, "_cmd_ready"}, cmd_ready, 1);
    chk({tag, "_wd_ready"},  wd_ready, 0);
    chk({tag, "_rd_valid"},  rd_valid, 0);
    chk({tag, "_busy"},      busy, 0);
    chk({tag, "_done"},      done, 0);
    chk({tag, "_m_en"},      m_en, 0);
    chk({tag, "_m_wr"},      m_wr, 0);
    chk({tag, "_m_addr"},    m_addr, 0);
    chk({tag, "_m_din"},     m_din, 0);
    chk({tag, "_rd_data"},   rd_data, 0);
  endtask

  task automatic run_burst(input bit wr, input logic [ADDR-1:0] addr, input int len,
                           input int mode, input logic [DATA-1:0] dbase,
                           input logic [DATA-1:0] dstep, output logic [ADDR-1:0] last_addr);
    int n, sent, issued, popped, first_issue, budget, outstanding;
    bit fin, pop, stim;
    logic [ADDR-1:0] a;
    logic [DATA-1:0] d;
    logic [DATA-1:0] exp_q [$];
    n = len + 1;
    sent = 0; issued = 0; popped = 0; first_issue = -1; fin = 1'b0;
    budget = 40 + 6 * n;
    last_addr = '0;
    for (int i = 0; i < n; i++) begin
      a = addr + ADDR'(i);
      exp_q.push_back(ref_mem[a]);
    end
    cmd_valid = 1'b1; cmd_wr = wr; cmd_addr = addr; cmd_len = ADDR'(len);
    @(negedge clk);
    chk("cmd_ready_idle", cmd_ready, 1);
    step();
    cmd_valid = 1'b0;
    for (int cyc = 0; cyc < budget && !fin; cyc++) begin
      stim = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 3 == 0) : 1'($urandom_range(0, 1));
      d = dbase + DATA'(sent) * dstep;
      if (wr) begin
        wd_valid = stim;
        rd_ready = 1'($urandom_range(0, 1));
      end else begin
        rd_ready = stim;
        wd_valid = 1'($urandom_range(0, 1));
      end
      wd_data = d;
      @(negedge clk);
      chk("busy", busy, 1);
      chk("done_mid", done, 0);
      chk("cmd_ready_busy", cmd_ready, 0);
      if (wr) begin
        chk("wd_ready", wd_ready, 1);
        chk("m_en_wr", m_en, wd_valid);
        chk("m_wr", m_wr, wd_valid);
        chk("rd_valid_wr", rd_valid, 0);
        if (wd_valid) begin
          a = addr + ADDR'(sent);
          chk("wr_addr", m_addr, a);
          chk("wr_din", m_din, d);
          ref_mem[a] = d;
          last_addr = m_addr;
          sent++;
          fin = (sent == n);
        end
      end else begin
        pop = rd_valid & rd_ready;
        outstanding = issued - popped;
        chk("wd_ready_rd", wd_ready, 0);
        chk("m_wr_rd", m_wr, 0);
        if (cyc == 0) chk("first_issue", m_en, 1);
        if (mode == 0 && first_issue >= 0) begin
          if (cyc < first_issue + 2) chk("rd_latency", rd_valid, 0);
          else                       chk("rd_stream", rd_valid, 1);
        end
        if (pop) begin
          chk("rd_data", rd_data, exp_q[popped]);
          popped++;
        end
        if (m_en) begin
          chk("issue_room", (issued < n) && (outstanding - int'(pop) < 2), 1);
          a = addr + ADDR'(issued);
          chk("rd_addr", m_addr, a);
          last_addr = m_addr;
          if (first_issue < 0) first_issue = cyc;
          issued++;
        end
        fin = (popped == n);
      end
      step();
    end
    chk("burst_complete", fin, 1);
    if (!wr) chk("issued_count", issued, n);
    wd_valid = 1'b0;
    rd_ready = 1'b1;
    @(negedge clk);
    chk("done_pulse", done, 1);
    chk("busy_end", busy, 0);
    chk("cmd_ready_end", cmd_ready, 1);
    chk("rd_valid_end", rd_valid, 0);
    chk("m_en_end", m_en, 0);
    step();
    @(negedge clk);
    chk("done_once", done, 0);
    step();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_total);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [ADDR-1:0] la, ra, exp_la;
    int pops, rlen;
    bit seen_done, rwr;

    vecs[0] = '{1'b1, 15'h0010, 3, 0, 8'h11, 8'h11, 15'h0013};
    vecs[1] = '{1'b0, 15'h0010, 3, 0, 8'h00, 8'h00, 15'h0013};
    vecs[2] = '{1'b0, 15'h000E, 5, 1, 8'h00, 8'h00, 15'h0013};
    vecs[3] = '{1'b1, 15'h7FFE, 3, 0, 8'hA0, 8'h01, 15'h0001};
    vecs[4] = '{1'b0, 15'h7FFD, 4, 2, 8'h00, 8'h00, 15'h0001};
    vecs[5] = '{1'b1, 15'h0100, 0, 2, 8'h5C, 8'h00, 15'h0100};

    for (int i = 0; i < MEM_WORDS; i++) begin
      ram[i]     = DATA'(i) ^ 8'h5A;
      ref_mem[i] = DATA'(i) ^ 8'h5A;
    end

    nRESET = 1'b0;
    cmd_valid = 1'b0; cmd_wr = 1'b0; cmd_addr = '0; cmd_len = '0;
    wd_valid = 1'b0; wd_data = '0; rd_ready = 1'b0;
    #1;
    check_reset("reset");
    repeat (2) @(posedge clk);
    #1;
    nRESET = 1'b1;

    for (int i = 0; i < NV; i++) begin
      run_burst(vecs[i].wr, vecs[i].addr, vecs[i].len, vecs[i].mode,
                vecs[i].dbase, vecs[i].dstep, la);
      chk($sformatf("vec%0d_last_addr", i), la, vecs[i].exp_last);
    end

    // single-word read with the next command already waiting on cmd_valid
    cmd_valid = 1'b1; cmd_wr = 1'b0; cmd_addr = 15'h0100; cmd_len = '0;
    rd_ready = 1'b1; wd_valid = 1'b0;
    @(negedge clk);
    chk("seqA_ready", cmd_ready, 1);
    step();
    cmd_addr = 15'h0200;
    pops = 0; seen_done = 1'b0;
    for (int c = 0; c < 20 && !seen_done; c++) begin
      @(negedge clk);
      if (rd_valid && rd_ready) begin
        chk("seqA_data", rd_data, ref_mem[15'h0100]);
        pops++;
      end
      if (done) begin
        seen_done = 1'b1;
        chk("seqA_ready_done", cmd_ready, 1);
      end else begin
        chk("seqA_hold", cmd_ready, 0);
      end
      step();
    end
    chk("seqA_done", seen_done, 1);
    chk("seqA_pops", pops, 1);
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("seqA_second_accepted", busy, 1);
    step();
    pops = 0; seen_done = 1'b0;
    for (int c = 0; c < 20 && !seen_done; c++) begin
      @(negedge clk);
      if (rd_valid && rd_ready) begin
        chk("seqA2_data", rd_data, ref_mem[15'h0200]);
        pops++;
      end
      if (done) seen_done = 1'b1;
      step();
    end
    chk("seqA2_done", seen_done, 1);
    chk("seqA2_pops", pops, 1);

    // reset in the middle of a 5-word read
    cmd_valid = 1'b1; cmd_wr = 1'b0; cmd_addr = 15'h0010; cmd_len = 15'd4; rd_ready = 1'b1;
    @(negedge clk);
    chk("seqB_ready", cmd_ready, 1);
    step();
    cmd_valid = 1'b0;
    pops = 0;
    for (int c = 0; c < 20 && pops < 2; c++) begin
      @(negedge clk);
      if (rd_valid && rd_ready) begin
        ra = 15'h0010 + ADDR'(pops);
        chk("seqB_data", rd_data, ref_mem[ra]);
        pops++;
      end
      if (pops < 2) step();
    end
    chk("seqB_two_pops", pops, 2);
    #2;
    nRESET = 1'b0;
    #1;
    check_reset("seqB_async");
    seen_done = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
      if (done) seen_done = 1'b1;
    end
    nRESET = 1'b1;
    @(negedge clk);
    chk("seqB_no_done", seen_done | done, 0);
    chk("seqB_idle", busy, 0);
    step();
    run_burst(1'b0, 15'h0010, 4, 0, 8'h00, 8'h00, la);
    chk("seqB_after_reset_last", la, 15'h0014);

    for (int r = 0; r < 12; r++) begin
      rwr  = 1'($urandom_range(0, 1));
      ra   = (r % 3 == 0) ? 15'h7FF8 + ADDR'($urandom_range(0, 7)) : ADDR'($urandom);
      rlen = $urandom_range(0, 12);
      run_burst(rwr, ra, rlen, 2, DATA'($urandom), DATA'($urandom) | 8'h01, la);
      exp_la = ra + ADDR'(rlen);
      chk("rand_last_addr", la, exp_la);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
